data_ram_responder: RTL and testbench

Data-memory responder for the 5-stage RV32I pipeline. It serves the memory stage's request (address, store data, 3-bit access-size control, read/write strobe), performs the byte/half/word store with lane masking, and returns load data already shifted and sign/zero-extended. Responses arrive after a parameterised latency, so the hazard unit can stall the pipeline while the block is busy.

---
 rtl/mem_pkg.sv | 61 ++++++
 rtl/data_ram_responder_load_align.sv | 13 +
 rtl/data_ram_responder.sv | 146 ++++++++++++++
 tb/tb_data_ram_responder.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared RV32I data-memory definitions: funct3 access codes, responder FSM states,
// and the byte-lane helpers used by both the responder and the writeback stage.
package mem_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic [3:0] byte_enable(input logic [1:0] lane, input logic [2:0] ctrl);
    logic [3:0] be;
    be = 4'b0000;
    case (ctrl)
      LB, LBU: be = 4'b0001 << lane;
      LH, LHU: be = lane[1] ? 4'b1100 : 4'b0011;
      LW:      be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Stores have no unsigned form, so LBU/LHU encodings are illegal for writes.
  function automatic logic access_error(input logic [1:0] lane, input logic [2:0] ctrl,
                                        input logic rw);
    logic bad;
    bad = 1'b1;
    case (ctrl)
      LB:      bad = 1'b0;
      LH:      bad = lane[0];
      LW:      bad = (lane != 2'b00);
      LBU:     bad = rw;
      LHU:     bad = rw | lane[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] lane,
                                              input logic [2:0] ctrl);
    logic [31:0] sh;
    logic [31:0] res;
    sh  = word >> {lane, 3'b000};
    res = sh;
    case (ctrl)
      LB:      res = {{24{sh[7]}}, sh[7:0]};
      LH:      res = {{16{sh[15]}}, sh[15:0]};
      LBU:     res = {24'd0, sh[7:0]};
      LHU:     res = {16'd0, sh[15:0]};
      default: res = sh;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/data_ram_responder_load_align.sv
// Combinational load lane extraction with sign/zero extension; shared with writeback.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  logic [2:0]  control_i,
  output logic [31:0] data_o
);

  assign data_o = load_extend(word_i, lane_i, control_i);

endmodule

// File: rtl/data_ram_responder.sv
// Data-memory responder for the RV32I memory stage: lane-masked stores, aligned and
// extended loads, and a fixed-latency one-cycle response strobe.
module data_ram_responder
  import mem_pkg::*;
#(
  parameter int size        = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_i,
  output logic            ready_o,
  input  logic [size-1:0] addr_i,
  input  logic [size-1:0] data_i,
  input  logic [2:0]      control_i,
  input  logic            rw_i,
  output logic            valid_o,
  output logic [size-1:0] data_o,
  output logic            err_o
);

  localparam int         IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [1:0] CNT_LOAD = (LATENCY > 1) ? 2'(LATENCY - 2) : 2'd0;

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] hold_word;

  state_t      state, next_state;
  logic [1:0]  count, count_next;
  logic [1:0]  cap_lane;
  logic [2:0]  cap_ctrl;
  logic        cap_rw, cap_err;

  logic [IDX_W-1:0] idx;
  logic             accept, err_now, load_resp;
  logic [3:0]       be;
  logic [31:0]      wdata_rep;
  logic [31:0]      src_word, aligned;
  logic [1:0]       src_lane;
  logic [2:0]       src_ctrl;
  logic             src_rw, src_err;

  assign idx     = addr_i[IDX_W+1:2];
  assign ready_o = (state == IDLE);
  assign valid_o = (state == RESP);
  assign accept  = req_i & ready_o;
  assign err_now = access_error(addr_i[1:0], control_i, rw_i);
  assign be      = byte_enable(addr_i[1:0], control_i);

  always_comb begin
    wdata_rep = data_i;
    case (control_i)
      LB:      wdata_rep = {4{data_i[7:0]}};
      LH:      wdata_rep = {2{data_i[15:0]}};
      default: wdata_rep = data_i;
    endcase
  end

  // Storage has no reset so it maps onto block RAM; reads land in hold_word.
  always_ff @(posedge clk) begin
    if (accept) begin
      hold_word <= mem[idx];
      if (rw_i && !err_now) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) mem[idx][8*b +: 8] <= wdata_rep[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    next_state = state;
    count_next = count;
    case (state)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            next_state = RESP;
          end else begin
            next_state = WAIT;
            count_next = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (count == 2'd0) next_state = RESP;
        else               count_next = count - 2'd1;
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // With LATENCY=1 the response is formed straight from the request; otherwise from captures.
  always_comb begin
    src_word = hold_word;
    src_lane = cap_lane;
    src_ctrl = cap_ctrl;
    src_rw   = cap_rw;
    src_err  = cap_err;
    if (state == IDLE) begin
      src_word = mem[idx];
      src_lane = addr_i[1:0];
      src_ctrl = control_i;
      src_rw   = rw_i;
      src_err  = err_now;
    end
  end

  load_align u_load_align (
    .word_i    (src_word),
    .lane_i    (src_lane),
    .control_i (src_ctrl),
    .data_o    (aligned)
  );

  assign load_resp = (next_state == RESP) && (state != RESP);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      count    <= 2'd0;
      cap_lane <= 2'd0;
      cap_ctrl <= 3'd0;
      cap_rw   <= 1'b0;
      cap_err  <= 1'b0;
      data_o   <= '0;
      err_o    <= 1'b0;
    end else begin
      state <= next_state;
      count <= count_next;
      if (accept) begin
        cap_lane <= addr_i[1:0];
        cap_ctrl <= control_i;
        cap_rw   <= rw_i;
        cap_err  <= err_now;
      end
      if (load_resp) begin
        data_o <= (src_err || src_rw) ? '0 : aligned;
        err_o  <= src_err;
      end
    end
  end

endmodule

// File: tb/tb_data_ram_responder.sv
// Self-checking bench: two responders (LATENCY 1 and 3) compared against a byte-array memory model.
module tb_data_ram_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req   [2];
  logic        rw    [2];
  logic        ready [2];
  logic        valid [2];
  logic        err   [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic [2:0]  ctrl  [2];

  logic [7:0]  model_mem [2][4096];
  int          assert_count = 0;
  int          fail_count   = 0;

  always #5 clk = ~clk;

  data_ram_responder #(.size(32), .DEPTH_WORDS(1024), .LATENCY(1)) dut_l1 (
    .clk(clk), .reset(rst_n), .req_i(req[0]), .ready_o(ready[0]), .addr_i(addr[0]),
    .data_i(wdata[0]), .control_i(ctrl[0]), .rw_i(rw[0]), .valid_o(valid[0]),
    .data_o(rdata[0]), .err_o(err[0])
  );

  data_ram_responder #(.size(32), .DEPTH_WORDS(1024), .LATENCY(3)) dut_l3 (
    .clk(clk), .reset(rst_n), .req_i(req[1]), .ready_o(ready[1]), .addr_i(addr[1]),
    .data_i(wdata[1]), .control_i(ctrl[1]), .rw_i(rw[1]), .valid_o(valid[1]),
    .data_o(rdata[1]), .err_o(err[1])
  );

  function automatic int lat_of(input int sel);
    return (sel == 0) ? 1 : 3;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Little-endian byte memory; access size, alignment and extension from the ISA rules.
  function automatic void model_access(input int sel, input logic [31:0] a, input logic [2:0] c,
                                       input logic r, input logic [31:0] d,
                                       output logic [31:0] exp_d, output logic exp_e);
    int n;
    int base;
    logic [31:0] val;
    case (c)
      3'b000, 3'b100: n = 1;
      3'b001, 3'b101: n = 2;
      3'b010:         n = 4;
      default:        n = 0;
    endcase
    if (n == 0) exp_e = 1'b1;
    else exp_e = ((int'(a[1:0]) % n) != 0) || (r && (c == 3'b100 || c == 3'b101));
    exp_d = 32'd0;
    base  = int'(a[11:0]);
    if (!exp_e) begin
      if (r) begin
        for (int i = 0; i < n; i++) model_mem[sel][base + i] = d[8*i +: 8];
      end else begin
        val = 32'd0;
        for (int i = 0; i < n; i++) val[8*i +: 8] = model_mem[sel][base + i];
        if (c == 3'b000 && val[7])  val = val | 32'hFFFF_FF00;
        if (c == 3'b001 && val[15]) val = val | 32'hFFFF_0000;
        exp_d = val;
      end
    end
  endfunction

  // Called and returns on a falling edge.
  task automatic applyStimulus(input int sel, input logic [31:0] a, input logic [2:0] c,
                               input logic r, input logic [31:0] d);
    logic [31:0] exp_d;
    logic        exp_e;
    int          waited;
    int          lat;
    waited = 0;
    while (!ready[sel] && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (!ready[sel]) begin
      checkOutput("ready_timeout", 32'd0, 32'd1);
      return;
    end
    req[sel] = 1'b1; addr[sel] = a; ctrl[sel] = c; rw[sel] = r; wdata[sel] = d;
    model_access(sel, a, c, r, d, exp_d, exp_e);
    @(posedge clk);
    lat = 0;
    for (int k = 1; k <= 8 && lat == 0; k++) begin
      @(negedge clk);
      if (k == 1) req[sel] = 1'b0;
      if (valid[sel]) lat = k;
    end
    checkOutput("latency", lat, lat_of(sel));
    if (lat != 0) begin
      checkOutput("data", rdata[sel], exp_d);
      checkOutput("err", {31'd0, err[sel]}, {31'd0, exp_e});
      checkOutput("ready_busy", {31'd0, ready[sel]}, 32'd0);
      @(negedge clk);
      checkOutput("valid_width", {31'd0, valid[sel]}, 32'd0);
      checkOutput("ready_back", {31'd0, ready[sel]}, 32'd1);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [2:0]  ctrl_tab [7];
    logic [31:0] exp_d;
    logic        exp_e;
    logic [31:0] a;
    logic [31:0] upper;
    int          first, last, vcount;

    ctrl_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110};
    for (int s = 0; s < 2; s++) begin
      req[s] = 1'b0; rw[s] = 1'b0; addr[s] = '0; wdata[s] = '0; ctrl[s] = 3'b010;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      checkOutput("rst_ready", {31'd0, ready[s]}, 32'd1);
      checkOutput("rst_valid", {31'd0, valid[s]}, 32'd0);
      checkOutput("rst_data", rdata[s], 32'd0);
      checkOutput("rst_err", {31'd0, err[s]}, 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Directed load/store patterns on the single-cycle responder.
    applyStimulus(0, 32'h10, 3'b010, 1'b1, 32'hDEADBEEF);
    applyStimulus(0, 32'h10, 3'b010, 1'b0, 32'h0);
    checkOutput("lw_deadbeef", rdata[0], 32'hDEADBEEF);
    applyStimulus(0, 32'h10, 3'b010, 1'b1, 32'h0);
    applyStimulus(0, 32'h13, 3'b000, 1'b1, 32'h0000_007F);
    applyStimulus(0, 32'h13, 3'b000, 1'b0, 32'h0);
    applyStimulus(0, 32'h10, 3'b010, 1'b0, 32'h0);
    checkOutput("lw_7f_top", rdata[0], 32'h7F00_0000);
    applyStimulus(0, 32'h12, 3'b000, 1'b1, 32'h0000_0080);
    applyStimulus(0, 32'h12, 3'b000, 1'b0, 32'h0);
    checkOutput("lb_sext", rdata[0], 32'hFFFF_FF80);
    applyStimulus(0, 32'h12, 3'b100, 1'b0, 32'h0);
    applyStimulus(0, 32'h20, 3'b010, 1'b1, 32'h0);
    applyStimulus(0, 32'h22, 3'b001, 1'b1, 32'h1234_BEEF);
    applyStimulus(0, 32'h22, 3'b001, 1'b0, 32'h0);
    applyStimulus(0, 32'h22, 3'b101, 1'b0, 32'h0);
    applyStimulus(0, 32'h20, 3'b010, 1'b0, 32'h0);
    applyStimulus(0, 32'h21, 3'b010, 1'b0, 32'h0);
    applyStimulus(0, 32'h23, 3'b001, 1'b1, 32'hFFFF_FFFF);
    applyStimulus(0, 32'h20, 3'b100, 1'b1, 32'hFFFF_FFFF);
    applyStimulus(0, 32'h20, 3'b011, 1'b0, 32'h0);
    applyStimulus(0, 32'h20, 3'b010, 1'b0, 32'h0);
    checkOutput("mem_unchanged", rdata[0], 32'hBEEF_0000);
    applyStimulus(0, 32'hABCD_E020, 3'b010, 1'b0, 32'h0);

    // Random traffic over 16 preloaded words, upper address bits randomised to exercise wrap.
    for (int s = 0; s < 2; s++) begin
      for (int w = 0; w < 16; w++) applyStimulus(s, 32'(w * 4), 3'b010, 1'b1, $urandom);
      for (int t = 0; t < 60; t++) begin
        upper = $urandom;
        a = {upper[19:0], 10'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
        applyStimulus(s, a, ctrl_tab[$urandom_range(0, 6)], 1'($urandom_range(0, 1)), $urandom);
      end
    end

    // Held request on the 3-cycle responder: responses every LATENCY+1 cycles.
    model_access(1, 32'h0, 3'b010, 1'b0, 32'h0, exp_d, exp_e);
    req[1] = 1'b1; addr[1] = 32'h0; ctrl[1] = 3'b010; rw[1] = 1'b0;
    first = -1; last = -1; vcount = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (valid[1]) begin
        if (first < 0) first = c;
        else checkOutput("b2b_gap", c - last, 32'd4);
        last = c;
        vcount++;
        checkOutput("b2b_data", rdata[1], exp_d);
      end
    end
    req[1] = 1'b0;
    checkOutput("b2b_first", first, 32'd3);
    checkOutput("b2b_count", vcount, 32'd5);
    @(negedge clk);

    // Reset mid-read drops the response; an earlier write survives.
    applyStimulus(1, 32'h40, 3'b010, 1'b1, 32'h1234_5678);
    req[1] = 1'b1; addr[1] = 32'h40; ctrl[1] = 3'b010; rw[1] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req[1] = 1'b0;
    checkOutput("busy_before_rst", {31'd0, ready[1]}, 32'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_async_valid", {31'd0, valid[1]}, 32'd0);
    checkOutput("rst_async_ready", {31'd0, ready[1]}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    vcount = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (valid[1]) vcount++;
    end
    checkOutput("no_valid_after_rst", vcount, 32'd0);
    checkOutput("ready_after_rst", {31'd0, ready[1]}, 32'd1);
    applyStimulus(1, 32'h40, 3'b010, 1'b0, 32'h0);
    checkOutput("write_survives_rst", rdata[1], 32'h1234_5678);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
